// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory port bundle for the image loader.
// The loader takes the slave side; the producer/memory environment takes the master side.
interface imem_loader_if;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  in_data;
   logic        in_last;
   logic [31:0] fetch_address;
   logic [31:0] mem_address;
   logic        mem_read_write;
   logic [31:0] mem_data_in;

   modport master (
      output in_valid, in_data, in_last, fetch_address,
      input  in_ready, mem_address, mem_read_write, mem_data_in
   );

   modport slave (
      input  in_valid, in_data, in_last, fetch_address,
      output in_ready, mem_address, mem_read_write, mem_data_in
   );
endinterface

// File: rtl/imem_loader.sv
// Packs a little-endian byte stream into 32-bit words and writes them into imemory
// from BASE_ADDR upward; outside of WRITE the core fetch address owns the memory port.
module imem_loader #(
   parameter logic [31:0] BASE_ADDR = 32'h01000000,
   parameter int          MAX_WORDS = 1024
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          start,
   imem_loader_if.slave  bus,
   output logic          busy,
   output logic          done,
   output logic          error,
   output logic [31:0]   word_count
);

   localparam logic [31:0] LP_MAX_WORDS = 32'(MAX_WORDS);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RECV,
      S_WRITE,
      S_DONE,
      S_ERR
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;

   logic [31:0] r_ptr;
   logic [31:0] r_count;
   logic [31:0] r_buf;
   logic [1:0]  r_byte_idx;
   logic        r_last;

   logic        w_in_ready;
   logic        w_write_en;
   logic        w_busy;
   logic        w_done;
   logic        w_error;
   logic        w_accept;
   logic        w_word_end;
   logic        w_room;
   logic        w_load;

   assign w_accept   = bus.in_valid && w_in_ready;
   assign w_word_end = w_accept && ((r_byte_idx == 2'd3) || bus.in_last);
   assign w_room     = (r_count < LP_MAX_WORDS);
   assign w_load     = start && ((r_state == S_IDLE) || (r_state == S_DONE));

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // in_ready depends only on r_state, never on in_valid
   always_comb begin
      w_state_nxt = r_state;
      w_in_ready  = 1'b0;
      w_write_en  = 1'b0;
      w_busy      = 1'b0;
      w_done      = 1'b0;
      w_error     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_state_nxt = S_RECV;
            end
         end
         S_RECV: begin
            w_in_ready = 1'b1;
            w_busy     = 1'b1;
            if (w_word_end) begin
               w_state_nxt = S_WRITE;
            end
         end
         S_WRITE: begin
            w_busy = 1'b1;
            if (w_room) begin
               w_write_en  = 1'b1;
               w_state_nxt = r_last ? S_DONE : S_RECV;
            end else begin
               w_state_nxt = S_ERR;
            end
         end
         S_DONE: begin
            w_done = 1'b1;
            if (start) begin
               w_state_nxt = S_RECV;
            end
         end
         S_ERR: begin
            w_error = 1'b1;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // The three update sources are mutually exclusive by state
   always_ff @(posedge clock) begin
      if (reset) begin
         r_ptr      <= BASE_ADDR;
         r_count    <= 32'd0;
         r_buf      <= 32'd0;
         r_byte_idx <= 2'd0;
         r_last     <= 1'b0;
      end else if (w_load) begin
         r_ptr      <= BASE_ADDR;
         r_count    <= 32'd0;
         r_buf      <= 32'd0;
         r_byte_idx <= 2'd0;
         r_last     <= 1'b0;
      end else if (w_accept) begin
         r_buf[{r_byte_idx, 3'b000} +: 8] <= bus.in_data;
         r_byte_idx                        <= r_byte_idx + 2'd1;
         if (w_word_end) begin
            r_last <= bus.in_last;
         end
      end else if (w_write_en) begin
         r_ptr      <= r_ptr + 32'd4;
         r_count    <= r_count + 32'd1;
         r_buf      <= 32'd0;
         r_byte_idx <= 2'd0;
      end
   end

   assign bus.in_ready       = w_in_ready;
   assign bus.mem_read_write = w_write_en;
   assign bus.mem_address    = (r_state == S_WRITE) ? r_ptr : bus.fetch_address;
   assign bus.mem_data_in    = r_buf;

   assign busy       = w_busy;
   assign done       = w_done;
   assign error      = w_error;
   assign word_count = r_count;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: one default-capacity instance and one with MAX_WORDS=2.
module tb_imem_loader;

   logic        clock = 1'b0;
   logic        rst0, rst1, start0, start1;
   logic        sel;
   logic        v_valid, v_last;
   logic [7:0]  v_data;
   logic [31:0] fetch;
   logic        busy0, done0, error0, busy1, done1, error1;
   logic [31:0] wc0, wc1;
   logic [63:0] log0[$];
   logic [63:0] log1[$];
   int          checks = 0;
   int          errors = 0;
   int          stalls = 0;

   imem_loader_if bus0 ();
   imem_loader_if bus1 ();

   assign bus0.in_valid      = v_valid & ~sel;
   assign bus1.in_valid      = v_valid & sel;
   assign bus0.in_data       = v_data;
   assign bus1.in_data       = v_data;
   assign bus0.in_last       = v_last;
   assign bus1.in_last       = v_last;
   assign bus0.fetch_address = fetch;
   assign bus1.fetch_address = fetch;

   imem_loader dut0 (
      .clock(clock), .reset(rst0), .start(start0), .bus(bus0.slave),
      .busy(busy0), .done(done0), .error(error0), .word_count(wc0)
   );

   imem_loader #(.BASE_ADDR(32'h01000000), .MAX_WORDS(2)) dut1 (
      .clock(clock), .reset(rst1), .start(start1), .bus(bus1.slave),
      .busy(busy1), .done(done1), .error(error1), .word_count(wc1)
   );

   always #5 clock = ~clock;

   always @(posedge clock) begin
      if (bus0.mem_read_write) log0.push_back({bus0.mem_address, bus0.mem_data_in});
      if (bus1.mem_read_write) log1.push_back({bus1.mem_address, bus1.mem_data_in});
   end

   task automatic pulse_start();
      if (sel) start1 = 1'b1; else start0 = 1'b1;
      @(negedge clock);
      start0 = 1'b0;
      start1 = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] d, input logic l);
      int  n;
      logic rdy;
      n = 0;
      v_data  = d;
      v_last  = l;
      v_valid = 1'b1;
      rdy = sel ? bus1.in_ready : bus0.in_ready;
      while (!rdy && n < 20) begin
         @(negedge clock);
         n++;
         stalls++;
         rdy = sel ? bus1.in_ready : bus0.in_ready;
      end
      if (n >= 20) begin
         checks++;
         errors++;
         $display("FAIL send_byte_timeout byte %h never accepted", d);
      end
      @(negedge clock);
   endtask

   task automatic test_reset();
      sel = 1'b0; v_valid = 1'b0; v_last = 1'b0; v_data = 8'h00;
      start0 = 1'b0; start1 = 1'b0;
      fetch = 32'h01000004;
      rst0 = 1'b1; rst1 = 1'b1;
      repeat (2) @(negedge clock);
      rst0 = 1'b0; rst1 = 1'b0;
      checks++; if (bus0.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b want 0", bus0.in_ready); end
      checks++; if ({busy0, done0, error0} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b want 000", {busy0, done0, error0}); end
      checks++; if (wc0 !== 32'd0) begin errors++; $display("FAIL reset_word_count got %h want 0", wc0); end
      checks++; if (bus0.mem_data_in !== 32'd0) begin errors++; $display("FAIL reset_mem_data_in got %h want 0", bus0.mem_data_in); end
      checks++; if (bus0.mem_read_write !== 1'b0) begin errors++; $display("FAIL reset_rw got %b want 0", bus0.mem_read_write); end
      checks++; if (bus0.mem_address !== 32'h01000004) begin errors++; $display("FAIL reset_mem_address got %h want 01000004", bus0.mem_address); end
   endtask

   task automatic test_basic_backpressure();
      logic [7:0] bytes [8] = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
      sel = 1'b0;
      log0.delete();
      stalls = 0;
      pulse_start();
      checks++; if ({busy0, bus0.in_ready} !== 2'b11) begin errors++; $display("FAIL start_busy_ready got %b want 11", {busy0, bus0.in_ready}); end
      for (int i = 0; i < 8; i++) send_byte(bytes[i], i == 7);
      v_valid = 1'b0; v_last = 1'b0;
      checks++; if (stalls !== 1) begin errors++; $display("FAIL basic_write_stalls got %0d want 1", stalls); end
      checks++; if ({bus0.mem_read_write, bus0.in_ready} !== 2'b10) begin errors++; $display("FAIL basic_write_cycle got %b want 10", {bus0.mem_read_write, bus0.in_ready}); end
      checks++; if (bus0.mem_address !== 32'h01000004) begin errors++; $display("FAIL basic_write_addr got %h want 01000004", bus0.mem_address); end
      checks++; if (bus0.mem_data_in !== 32'h00100093) begin errors++; $display("FAIL basic_write_data got %h want 00100093", bus0.mem_data_in); end
      @(negedge clock);
      checks++; if ({done0, busy0} !== 2'b10) begin errors++; $display("FAIL basic_done got %b want 10", {done0, busy0}); end
      checks++; if (wc0 !== 32'd2) begin errors++; $display("FAIL basic_word_count got %0d want 2", wc0); end
      checks++; if (log0.size() !== 2) begin errors++; $display("FAIL basic_write_count got %0d want 2", log0.size()); end
      else begin
         checks++; if (log0[0] !== 64'h01000000_00000013) begin errors++; $display("FAIL basic_word0 got %h want 0100000000000013", log0[0]); end
         checks++; if (log0[1] !== 64'h01000004_00100093) begin errors++; $display("FAIL basic_word1 got %h want 0100000400100093", log0[1]); end
      end
   endtask

   task automatic test_gaps();
      logic [7:0] bytes [8] = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
      sel = 1'b0;
      log0.delete();
      pulse_start();
      checks++; if (wc0 !== 32'd0) begin errors++; $display("FAIL restart_word_count got %0d want 0", wc0); end
      for (int i = 0; i < 8; i++) begin
         v_valid = 1'b0;
         repeat ($urandom_range(3, 0)) @(negedge clock);
         send_byte(bytes[i], i == 7);
      end
      v_valid = 1'b0; v_last = 1'b0;
      repeat (2) @(negedge clock);
      checks++; if ({done0, wc0} !== {1'b1, 32'd2}) begin errors++; $display("FAIL gaps_done_count got %b/%0d want 1/2", done0, wc0); end
      checks++; if (log0.size() !== 2) begin errors++; $display("FAIL gaps_write_count got %0d want 2", log0.size()); end
      else begin
         checks++; if (log0[0] !== 64'h01000000_00000013) begin errors++; $display("FAIL gaps_word0 got %h want 0100000000000013", log0[0]); end
         checks++; if (log0[1] !== 64'h01000004_00100093) begin errors++; $display("FAIL gaps_word1 got %h want 0100000400100093", log0[1]); end
      end
   endtask

   task automatic test_partial();
      sel = 1'b0;
      log0.delete();
      pulse_start();
      send_byte(8'hAA, 1'b0);
      send_byte(8'hBB, 1'b1);
      v_valid = 1'b0; v_last = 1'b0;
      @(negedge clock);
      checks++; if ({done0, wc0} !== {1'b1, 32'd1}) begin errors++; $display("FAIL partial_done_count got %b/%0d want 1/1", done0, wc0); end
      checks++; if (log0.size() !== 1) begin errors++; $display("FAIL partial_write_count got %0d want 1", log0.size()); end
      else begin
         checks++; if (log0[0] !== 64'h01000000_0000BBAA) begin errors++; $display("FAIL partial_word got %h want 010000000000BBAA", log0[0]); end
      end
   endtask

   task automatic test_fetch();
      fetch = 32'h01000004;
      @(negedge clock);
      checks++; if ({bus0.mem_address, bus0.mem_read_write} !== {32'h01000004, 1'b0}) begin errors++; $display("FAIL fetch_done got %h/%b want 01000004/0", bus0.mem_address, bus0.mem_read_write); end
      fetch = 32'h00000040;
      #1;
      checks++; if (bus0.mem_address !== 32'h00000040) begin errors++; $display("FAIL fetch_comb got %h want 00000040", bus0.mem_address); end
   endtask

   task automatic test_reset_midload();
      sel = 1'b0;
      log0.delete();
      pulse_start();
      send_byte(8'h11, 1'b0);
      send_byte(8'h22, 1'b0);
      v_valid = 1'b0;
      rst0 = 1'b1;
      @(negedge clock);
      rst0 = 1'b0;
      repeat (2) @(negedge clock);
      checks++; if (log0.size() !== 0) begin errors++; $display("FAIL midreset_writes got %0d want 0", log0.size()); end
      checks++; if ({busy0, done0, error0, bus0.in_ready, bus0.mem_read_write} !== 5'b0) begin errors++; $display("FAIL midreset_flags got %b want 00000", {busy0, done0, error0, bus0.in_ready, bus0.mem_read_write}); end
      checks++; if ({wc0, bus0.mem_data_in} !== 64'd0) begin errors++; $display("FAIL midreset_count_data got %h/%h want 0/0", wc0, bus0.mem_data_in); end
   endtask

   task automatic test_overflow();
      sel = 1'b1;
      log1.delete();
      pulse_start();
      for (int i = 0; i < 12; i++) send_byte(8'(i + 1), 1'b0);
      v_valid = 1'b0;
      checks++; if ({busy1, bus1.mem_read_write} !== 2'b10) begin errors++; $display("FAIL ovf_suppressed got %b want 10", {busy1, bus1.mem_read_write}); end
      checks++; if (bus1.mem_address !== 32'h01000008) begin errors++; $display("FAIL ovf_addr got %h want 01000008", bus1.mem_address); end
      @(negedge clock);
      checks++; if ({error1, busy1, done1, bus1.in_ready} !== 4'b1000) begin errors++; $display("FAIL ovf_error got %b want 1000", {error1, busy1, done1, bus1.in_ready}); end
      checks++; if (log1.size() !== 2) begin errors++; $display("FAIL ovf_write_count got %0d want 2", log1.size()); end
      else begin
         checks++; if (log1[1] !== 64'h01000004_08070605) begin errors++; $display("FAIL ovf_word1 got %h want 0100000408070605", log1[1]); end
      end
      checks++; if (wc1 !== 32'd2) begin errors++; $display("FAIL ovf_word_count got %0d want 2", wc1); end
      pulse_start();
      @(negedge clock);
      checks++; if ({error1, busy1} !== 2'b10) begin errors++; $display("FAIL ovf_sticky got %b want 10", {error1, busy1}); end
      rst1 = 1'b1;
      @(negedge clock);
      rst1 = 1'b0;
      checks++; if ({error1, wc1} !== {1'b0, 32'd0}) begin errors++; $display("FAIL ovf_reset got %b/%0d want 0/0", error1, wc1); end
      sel = 1'b0;
   endtask

   initial begin
      rst0 = 1'b1; rst1 = 1'b1; start0 = 1'b0; start1 = 1'b0;
      sel = 1'b0; v_valid = 1'b0; v_last = 1'b0; v_data = 8'h00;
      fetch = 32'h0;
      @(negedge clock);
      test_reset();
      test_basic_backpressure();
      test_fetch();
      test_gaps();
      test_partial();
      test_fetch();
      test_reset_midload();
      test_overflow();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/imem_loader.md
# imem_loader

Write-side companion to the instruction memory fetch path. It accepts a program image as a byte stream over a valid/ready handshake and packs the bytes little-endian into 32-bit words. It writes those words into `imemory` at consecutive addresses starting at the text base. When idle or finished, it passes the core's fetch address through to the memory read port, so one memory instance serves both loading and fetch.

## Interface

Parameters:
- `BASE_ADDR`, default 32'h01000000: address of the first written word.
- `MAX_WORDS`, default 1024: image capacity in words. Exceeding it is an error.

Ports:
- `clock`, in, 1: sole clock. All state updates on its rising edge.
- `reset`, in, 1: synchronous, active-high.
- `start`, in, 1: begins a load. Sampled in IDLE and DONE only.
- `in_valid`, in, 1: byte available on `in_data`.
- `in_ready`, out, 1: loader accepts a byte this cycle.
- `in_data`, in, 8: image byte.
- `in_last`, in, 1: qualifies the final byte of the image. Meaningful only when `in_valid`.
- `fetch_address`, in, 32: core fetch address, passed through when not loading.
- `mem_address`, out, 32: to `imemory.address`.
- `mem_read_write`, out, 1: to `imemory.read_write`. 1 means write.
- `mem_data_in`, out, 32: to `imemory.data_in`.
- `busy`, out, 1: high in RECV and WRITE.
- `done`, out, 1: high in DONE.
- `error`, out, 1: high in ERR.
- `word_count`, out, 32: words written in the current or most recent load.

## Operation

State machine has five states: IDLE, RECV, WRITE, DONE, ERR. The state is registered.

- **IDLE**
  - `in_ready`=0.
  - On `start`: go to RECV, write pointer ← `BASE_ADDR`, byte index ← 0, `word_count` ← 0, word buffer ← 0, last flag ← 0.
- **RECV**
  - `in_ready`=1.
  - A byte is accepted when `in_valid && in_ready`. It goes into buffer lane `byte_idx` (lane 0 = bits 7:0).
  - After acceptance, `byte_idx` increments.
  - If the accepted byte had `byte_idx`==3 or `in_last`=1: go to WRITE, and latch the last flag from `in_last`.
  - Lanes not filled before `in_last` stay zero.
  - `start` is ignored.
- **WRITE** (exactly one cycle)
  - `in_ready`=0.
  - If `word_count` < `MAX_WORDS`:
    - `mem_read_write`=1, `mem_address`=write pointer, `mem_data_in`=buffer.
    - Next cycle: pointer += 4, `word_count` += 1, buffer ← 0, `byte_idx` ← 0.
    - Go to DONE if the last flag is set, else go to RECV.
  - If `word_count` == `MAX_WORDS`:
    - The write is suppressed (`mem_read_write`=0).
    - Go to ERR.
- **DONE**
  - `done`=1 and `in_ready`=0. Pointer and count hold.
  - `start` restarts exactly as from IDLE.
- **ERR**
  - `error`=1 and `in_ready`=0.
  - Sticky. Only `reset` leaves this state.
  - `start` is ignored.

Memory port mux:
- In WRITE, `mem_address` = write pointer.
- In all other states, `mem_address` = `fetch_address` (combinational pass-through) and `mem_read_write`=0.
- Write pointer arithmetic is 32-bit and wraps modulo 2^32 without special handling.

## Timing

- **Reset:** state IDLE. Pointer = `BASE_ADDR`. `word_count`=0, buffer=0, `mem_data_in`=0. `mem_read_write`, `in_ready`, `busy`, `done`, `error` all 0. `mem_address` = `fetch_address`.
- **Start latency:** `start` high at edge N puts RECV in effect from N; `in_ready`=1 in the cycle after edge N.
- **Handshake:**
  - `in_ready` is a function of registered state only, with no combinational path from `in_valid`.
  - A byte transfers on any edge where both signals are high.
  - The producer may hold `in_valid` high across WRITE cycles; the byte is not consumed until `in_ready` returns.
- **Write timing:** the 4th byte, or the `in_last` byte, is accepted at edge K. WRITE is presented during cycle K→K+1, and `imemory` captures the word at edge K+1.
- **Throughput:** peak is 5 cycles per word (4 accept + 1 write).
- **DONE timing:** `done` rises the cycle after the final WRITE.
- **Reset mid-load:** the partial word is discarded, no write is issued, and `word_count` returns to 0.

## Test plan

- **Basic load:** reset, `start`, stream bytes 0x13,0x00,0x00,0x00,0x93,0x00,0x10,0x00 (`in_last` on the 8th) → writes 0x00000013 @0x01000000 and 0x00100093 @0x01000004. Then `done`=1, `word_count`=2.
- **Partial word:** stream 0xAA,0xBB with `in_last` on 0xBB → single write 0x0000BBAA @0x01000000, then `done`=1, `word_count`=1.
- **Backpressure and stalls:**
  - Hold `in_valid`=1 continuously for 8 bytes → `in_ready` low during each WRITE cycle, no byte lost or duplicated, words match.
  - Insert random `in_valid` gaps → same memory contents.
- **Overflow:** `MAX_WORDS`=2, stream 12 bytes with no `in_last` → two writes occur, the third is suppressed, `error`=1. `error` stays high after `start`, and clears only on `reset`.
- **Fetch pass-through and restart:**
  - In IDLE and DONE, `fetch_address`=0x01000004 → `mem_address`=0x01000004 and `mem_read_write`=0.
  - `start` from DONE → pointer back to 0x01000000 and `word_count`=0.
- **Reset mid-load:** assert `reset` after 2 bytes → no write occurs, state IDLE, all outputs at reset values.
